// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bus: instruction handshake plus the data-memory load return.
interface writeback_stage_if;
   logic        memValid;
   logic        memReady;
   logic        memDestEnable;
   logic [4:0]  memDestAddress;
   logic [31:0] memResult;
   logic        memIsLoad;
   logic [2:0]  memLoadFunct3;
   logic [1:0]  memByteOffset;
   logic        loadDataValid;
   logic [31:0] loadData;

   modport master (
      output memValid, memDestEnable, memDestAddress, memResult, memIsLoad,
             memLoadFunct3, memByteOffset, loadDataValid, loadData,
      input  memReady
   );

   modport slave (
      input  memValid, memDestEnable, memDestAddress, memResult, memIsLoad,
             memLoadFunct3, memByteOffset, loadDataValid, loadData,
      output memReady
   );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: single-entry capture buffer, load formatting and fault detection,
// registered register-file write port and retired-instruction counter.
//
// state     | meaning
// IDLE      | no instruction held, ready to accept
// WAIT_LOAD | load accepted, waiting for loadDataValid
// COMMIT    | one-cycle register-file write / commit strobe, ready to accept
module writeback_stage (
   input  logic              clock,
   input  logic              reset,
   writeback_stage_if.slave  mem,
   output logic              destinationEnable,
   output logic [4:0]        writeAddress,
   output logic [31:0]       writeData,
   output logic              memoryWritebackValid,
   output logic              loadFault,
   output logic [31:0]       retireCount
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_LOAD = 2'd1;
   localparam logic [1:0] COMMIT    = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        cap_dest_en_q, cap_dest_en_d;
   logic [4:0]  cap_addr_q, cap_addr_d;
   logic [31:0] cap_result_q, cap_result_d;
   logic        cap_is_load_q, cap_is_load_d;
   logic [2:0]  cap_f3_q, cap_f3_d;
   logic [1:0]  cap_off_q, cap_off_d;

   logic        dest_enable_q, dest_enable_d;
   logic [4:0]  write_address_q, write_address_d;
   logic [31:0] write_data_q, write_data_d;
   logic        wb_valid_q, wb_valid_d;
   logic        load_fault_q, load_fault_d;
   logic [31:0] retire_count_q, retire_count_d;

   logic        accept;
   logic [31:0] shifted;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_value;
   logic        load_bad;

   logic        commit_go;
   logic        commit_en;
   logic [4:0]  commit_addr;
   logic [31:0] commit_data;
   logic        commit_fault;

   assign mem.memReady = !reset && (state_q != WAIT_LOAD);
   assign accept       = mem.memValid && mem.memReady;

   always_comb begin
      shifted    = mem.loadData >> {cap_off_q, 3'b000};
      lane_byte  = shifted[7:0];
      lane_half  = cap_off_q[1] ? mem.loadData[31:16] : mem.loadData[15:0];
      load_value = 32'd0;
      load_bad   = 1'b0;
      case (cap_f3_q)
         3'b000: load_value = {{24{lane_byte[7]}}, lane_byte};
         3'b001: begin
            load_value = {{16{lane_half[15]}}, lane_half};
            load_bad   = cap_off_q[0];
         end
         3'b010: begin
            load_value = mem.loadData;
            load_bad   = (cap_off_q != 2'd0);
         end
         3'b100: load_value = {24'd0, lane_byte};
         3'b101: begin
            load_value = {16'd0, lane_half};
            load_bad   = cap_off_q[0];
         end
         default: load_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cap_dest_en_d = cap_dest_en_q;
      cap_addr_d    = cap_addr_q;
      cap_result_d  = cap_result_q;
      cap_is_load_d = cap_is_load_q;
      cap_f3_d      = cap_f3_q;
      cap_off_d     = cap_off_q;
      commit_go     = 1'b0;
      commit_en     = 1'b0;
      commit_addr   = 5'd0;
      commit_data   = 32'd0;
      commit_fault  = 1'b0;

      case (state_q)
         IDLE, COMMIT: begin
            state_d = IDLE;
            if (accept) begin
               cap_dest_en_d = mem.memDestEnable;
               cap_addr_d    = mem.memDestAddress;
               cap_result_d  = mem.memResult;
               cap_is_load_d = mem.memIsLoad;
               cap_f3_d      = mem.memLoadFunct3;
               cap_off_d     = mem.memByteOffset;
               if (mem.memIsLoad) begin
                  state_d = WAIT_LOAD;
               end else begin
                  // Non-loads commit straight from the bus to keep latency at one cycle.
                  state_d     = COMMIT;
                  commit_go   = 1'b1;
                  commit_en   = mem.memDestEnable;
                  commit_addr = mem.memDestAddress;
                  commit_data = mem.memResult;
               end
            end
         end
         WAIT_LOAD: begin
            if (mem.loadDataValid) begin
               state_d      = COMMIT;
               commit_go    = 1'b1;
               commit_en    = cap_dest_en_q;
               commit_addr  = cap_addr_q;
               commit_fault = cap_is_load_q && load_bad;
               commit_data  = cap_is_load_q ? (load_bad ? 32'd0 : load_value) : cap_result_q;
            end
         end
         default: state_d = IDLE;
      endcase

      dest_enable_d   = commit_go && commit_en && (commit_addr != 5'd0) && !commit_fault;
      write_address_d = commit_go ? commit_addr : 5'd0;
      write_data_d    = commit_go ? commit_data : 32'd0;
      wb_valid_d      = commit_go;
      load_fault_d    = commit_go && commit_fault;
      retire_count_d  = commit_go ? retire_count_q + 32'd1 : retire_count_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         cap_dest_en_q   <= 1'b0;
         cap_addr_q      <= 5'd0;
         cap_result_q    <= 32'd0;
         cap_is_load_q   <= 1'b0;
         cap_f3_q        <= 3'd0;
         cap_off_q       <= 2'd0;
         dest_enable_q   <= 1'b0;
         write_address_q <= 5'd0;
         write_data_q    <= 32'd0;
         wb_valid_q      <= 1'b0;
         load_fault_q    <= 1'b0;
         retire_count_q  <= 32'd0;
      end else begin
         state_q         <= state_d;
         cap_dest_en_q   <= cap_dest_en_d;
         cap_addr_q      <= cap_addr_d;
         cap_result_q    <= cap_result_d;
         cap_is_load_q   <= cap_is_load_d;
         cap_f3_q        <= cap_f3_d;
         cap_off_q       <= cap_off_d;
         dest_enable_q   <= dest_enable_d;
         write_address_q <= write_address_d;
         write_data_q    <= write_data_d;
         wb_valid_q      <= wb_valid_d;
         load_fault_q    <= load_fault_d;
         retire_count_q  <= retire_count_d;
      end
   end

   assign destinationEnable    = dest_enable_q;
   assign writeAddress         = write_address_q;
   assign writeData            = write_data_q;
   assign memoryWritebackValid = wb_valid_q;
   assign loadFault            = load_fault_q;
   assign retireCount          = retire_count_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU commit, load formatting, faults,
// back-to-back throughput, reset while waiting, counter wrap.
module tb_writeback_stage;
   logic        clock;
   logic        reset;
   logic        destinationEnable;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic        memoryWritebackValid;
   logic        loadFault;
   logic [31:0] retireCount;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] exp_retire = 32'd0;

   writeback_stage_if mif ();

   writeback_stage dut (
      .clock               (clock),
      .reset               (reset),
      .mem                 (mif.slave),
      .destinationEnable   (destinationEnable),
      .writeAddress        (writeAddress),
      .writeData           (writeData),
      .memoryWritebackValid(memoryWritebackValid),
      .loadFault           (loadFault),
      .retireCount         (retireCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {destinationEnable, writeAddress, writeData, memoryWritebackValid, loadFault}
   function automatic logic [39:0] outs();
      return {destinationEnable, writeAddress, writeData, memoryWritebackValid, loadFault};
   endfunction

   task automatic drive_mem(input logic v, input logic en, input logic [4:0] addr,
                            input logic [31:0] res, input logic ld, input logic [2:0] f3,
                            input logic [1:0] off);
      mif.memValid       = v;
      mif.memDestEnable  = en;
      mif.memDestAddress = addr;
      mif.memResult      = res;
      mif.memIsLoad      = ld;
      mif.memLoadFunct3  = f3;
      mif.memByteOffset  = off;
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
      mif.loadDataValid = 1'b0;
      mif.loadData      = 32'd0;
      @(negedge clock);
      step();
      tests_run++;
      if (mif.memReady !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ready_low: got %b want 0", mif.memReady);
      end
      reset = 1'b0;
      step();
      tests_run++;
      if ({outs(), retireCount, mif.memReady} !== {40'd0, 32'd0, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_state: outs=%h retire=%h ready=%b want 0/0/1",
                  outs(), retireCount, mif.memReady);
      end
      exp_retire = 32'd0;
   endtask

   task automatic test_alu();
      drive_mem(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
      step();
      drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
      exp_retire = exp_retire + 32'd1;
      tests_run++;
      if ({outs(), retireCount} !== {1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, exp_retire}) begin
         tests_failed++;
         $display("FAIL alu_commit: outs=%h retire=%h want rd5 0x12345678 retire=%h",
                  outs(), retireCount, exp_retire);
      end
      step();
      tests_run++;
      if ({outs(), mif.memReady} !== {40'd0, 1'b1}) begin
         tests_failed++;
         $display("FAIL alu_idle_after: outs=%h ready=%b want 0/1", outs(), mif.memReady);
      end
   endtask

   task automatic test_load();
      logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      logic [1:0]  off [6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
      logic [31:0] dat [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                               32'h80FF_0000, 32'h80FF_0000, 32'h0000_7F00};
      logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_80FF, 32'h80FF_0000, 32'h0000_007F};
      for (int i = 0; i < 6; i++) begin
         drive_mem(1'b1, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1, f3[i], off[i]);
         mif.loadDataValid = 1'b1;
         mif.loadData      = 32'hFFFF_FFFF;
         step();
         drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
         mif.loadDataValid = 1'b0;
         step();
         tests_run++;
         if ({mif.memReady, memoryWritebackValid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL load_wait[%0d]: ready=%b wbvalid=%b want 0/0",
                     i, mif.memReady, memoryWritebackValid);
         end
         mif.loadDataValid = 1'b1;
         mif.loadData      = dat[i];
         step();
         mif.loadDataValid = 1'b0;
         exp_retire = exp_retire + 32'd1;
         tests_run++;
         if ({outs(), retireCount} !== {1'b1, 5'd10, exp[i], 1'b1, 1'b0, exp_retire}) begin
            tests_failed++;
            $display("FAIL load_commit[%0d]: outs=%h retire=%h want data=%h retire=%h",
                     i, outs(), retireCount, exp[i], exp_retire);
         end
         step();
      end
   endtask

   task automatic test_fault();
      logic [2:0] f3  [3] = '{3'b010, 3'b011, 3'b101};
      logic [1:0] off [3] = '{2'd2, 2'd0, 2'd1};
      for (int i = 0; i < 3; i++) begin
         drive_mem(1'b1, 1'b1, 5'd9, 32'd0, 1'b1, f3[i], off[i]);
         step();
         drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
         mif.loadDataValid = 1'b1;
         mif.loadData      = 32'hA5A5_5A5A;
         step();
         mif.loadDataValid = 1'b0;
         exp_retire = exp_retire + 32'd1;
         tests_run++;
         if ({destinationEnable, writeData, memoryWritebackValid, loadFault, retireCount}
             !== {1'b0, 32'd0, 1'b1, 1'b1, exp_retire}) begin
            tests_failed++;
            $display("FAIL fault_commit[%0d]: outs=%h retire=%h want fault, retire=%h",
                     i, outs(), retireCount, exp_retire);
         end
         step();
         tests_run++;
         if ({loadFault, memoryWritebackValid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL fault_pulse[%0d]: fault=%b wbvalid=%b want 0/0",
                     i, loadFault, memoryWritebackValid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  rd  [4] = '{5'd1, 5'd0, 5'd7, 5'd31};
      logic [31:0] res [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      logic        en  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) begin
            exp_retire = exp_retire + 32'd1;
            tests_run++;
            if ({outs(), retireCount, mif.memReady}
                !== {en[i-1], rd[i-1], res[i-1], 1'b1, 1'b0, exp_retire, 1'b1}) begin
               tests_failed++;
               $display("FAIL b2b_commit[%0d]: outs=%h retire=%h ready=%b want en=%b rd=%0d data=%h",
                        i - 1, outs(), retireCount, mif.memReady, en[i-1], rd[i-1], res[i-1]);
            end
         end
         if (i < 4) drive_mem(1'b1, 1'b1, rd[i], res[i], 1'b0, 3'd0, 2'd0);
         else       drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
         step();
      end
      tests_run++;
      if (outs() !== 40'd0) begin
         tests_failed++;
         $display("FAIL b2b_drain: outs=%h want 0", outs());
      end
   endtask

   task automatic test_reset_wait();
      drive_mem(1'b1, 1'b1, 5'd3, 32'd0, 1'b1, 3'b010, 2'd0);
      step();
      drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      mif.loadDataValid = 1'b1;
      mif.loadData      = 32'hCAFE_F00D;
      step();
      mif.loadDataValid = 1'b0;
      exp_retire = 32'd0;
      tests_run++;
      if ({outs(), retireCount, mif.memReady} !== {40'd0, 32'd0, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_wait: outs=%h retire=%h ready=%b want 0/0/1",
                  outs(), retireCount, mif.memReady);
      end
      step();
      tests_run++;
      if ({memoryWritebackValid, retireCount} !== {1'b0, 32'd0}) begin
         tests_failed++;
         $display("FAIL reset_wait_late: wbvalid=%b retire=%h want 0/0",
                  memoryWritebackValid, retireCount);
      end
   endtask

   task automatic test_wrap();
      force dut.retire_count_q = 32'hFFFF_FFFF;
      step();
      release dut.retire_count_q;
      step();
      tests_run++;
      if (retireCount !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL wrap_preset: got %h want ffffffff", retireCount);
      end
      drive_mem(1'b1, 1'b1, 5'd2, 32'h0000_00AA, 1'b0, 3'd0, 2'd0);
      step();
      tests_run++;
      if (retireCount !== 32'd0) begin
         tests_failed++;
         $display("FAIL wrap_zero: got %h want 0", retireCount);
      end
      step();
      drive_mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
      tests_run++;
      if (retireCount !== 32'd1) begin
         tests_failed++;
         $display("FAIL wrap_next: got %h want 1", retireCount);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_fault();
      test_back_to_back();
      test_reset_wait();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
